// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared encodings for the instruction-fetch sequencer
// Contents: 3-bit state encodings with the matching state enum,
//           RW_READ/RW_WRITE bus direction constants,
//           and TO_CNT_W, the timeout counter width.
package fetch_pkg;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LOAD_MAR = 3'd1;
   localparam logic [2:0] S_MEM_WAIT = 3'd2;
   localparam logic [2:0] S_LOAD_IR  = 3'd3;
   localparam logic [2:0] S_DONE     = 3'd4;
   localparam logic [2:0] S_ERR      = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE     = S_IDLE,
      ST_LOAD_MAR = S_LOAD_MAR,
      ST_MEM_WAIT = S_MEM_WAIT,
      ST_LOAD_IR  = S_LOAD_IR,
      ST_DONE     = S_DONE,
      ST_ERR      = S_ERR
   } fetch_state_t;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   localparam int TO_CNT_W = 8;

endpackage

// File: rtl/fetch_timeout_counter.sv
// rtl/fetch_timeout_counter.sv - saturating MEM_WAIT timeout counter
// Ports: CLK, RESET (sync, active-high), CLR (sync clear), INC (count one cycle),
//        LIMIT[7:0] (saturation/expiry value), EXPIRED (this INC reaches LIMIT).
module fetch_timeout_counter
   import fetch_pkg::*;
(
   input  logic                CLK,
   input  logic                RESET,
   input  logic                CLR,
   input  logic                INC,
   input  logic [TO_CNT_W-1:0] LIMIT,
   output logic                EXPIRED
);

   logic [TO_CNT_W-1:0] cnt;
   logic [TO_CNT_W:0]   cnt_inc;

   assign cnt_inc = {1'b0, cnt} + 9'd1;

   // EXPIRED looks at the post-increment count so the FSM can leave on the
   // same edge the count reaches LIMIT (exactly LIMIT waiting cycles).
   assign EXPIRED = INC && (cnt_inc >= {1'b0, LIMIT});

   always_ff @(posedge CLK) begin
      if (RESET || CLR)
         cnt <= '0;
      else if (INC && (cnt != LIMIT))
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/mem_fetch_sequencer.sv
// rtl/mem_fetch_sequencer.sv - multi-cycle instruction-fetch controller
// Optional build macro: FETCH_ALIGN_CHECK_EN (misaligned PC_Q goes straight to ERR).
// Inputs:  CLK, RESET (sync, active-high), FETCH_REQ, STALL, PC_Q[31:0], MFC.
// Outputs: MAR_EN, MOV, RW, MDR_EN, IR_EN, PC_EN, PC_D[31:0], BUSY,
//          FETCH_DONE, FETCH_ERR.
module mem_fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [31:0] PC_INC         = 32'd4,
   parameter int unsigned TIMEOUT_CYCLES = 15
)
(
   input  logic        CLK,
   input  logic        RESET,
   input  logic        FETCH_REQ,
   input  logic        STALL,
   input  logic [31:0] PC_Q,
   input  logic        MFC,
   output logic        MAR_EN,
   output logic        MOV,
   output logic        RW,
   output logic        MDR_EN,
   output logic        IR_EN,
   output logic        PC_EN,
   output logic [31:0] PC_D,
   output logic        BUSY,
   output logic        FETCH_DONE,
   output logic        FETCH_ERR
);

   localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(TIMEOUT_CYCLES);

   fetch_state_t state, state_nxt;
   logic         to_clr, to_inc, to_expired;

   fetch_timeout_counter u_timeout (
      .CLK     (CLK),
      .RESET   (RESET),
      .CLR     (to_clr),
      .INC     (to_inc),
      .LIMIT   (TO_LIMIT),
      .EXPIRED (to_expired)
   );

   always_ff @(posedge CLK) begin
      if (RESET)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      to_clr     = 1'b0;
      to_inc     = 1'b0;
      MAR_EN     = 1'b0;
      MOV        = 1'b0;
      RW         = 1'b0;
      MDR_EN     = 1'b0;
      IR_EN      = 1'b0;
      PC_EN      = 1'b0;
      PC_D       = 32'd0;
      BUSY       = (state != ST_IDLE);
      FETCH_DONE = 1'b0;
      FETCH_ERR  = 1'b0;

      case (state)
         ST_IDLE: begin
            if (FETCH_REQ && !STALL) begin
`ifdef FETCH_ALIGN_CHECK_EN
               if (PC_Q[1:0] != 2'b00)
                  state_nxt = ST_ERR;
               else
                  state_nxt = ST_LOAD_MAR;
`else
               state_nxt = ST_LOAD_MAR;
`endif
            end
         end
         ST_LOAD_MAR: begin
            MAR_EN    = 1'b1;
            to_clr    = 1'b1;
            state_nxt = ST_MEM_WAIT;
         end
         ST_MEM_WAIT: begin
            MOV    = 1'b1;
            RW     = RW_READ;
            MDR_EN = MFC;
            // MFC has priority over a coincident expiry.
            if (MFC) begin
               state_nxt = ST_LOAD_IR;
            end else begin
               to_inc = 1'b1;
               if (to_expired)
                  state_nxt = ST_ERR;
            end
         end
         ST_LOAD_IR: begin
            IR_EN     = 1'b1;
            PC_EN     = 1'b1;
            PC_D      = PC_Q + PC_INC;
            state_nxt = ST_DONE;
         end
         ST_DONE: begin
            FETCH_DONE = 1'b1;
            state_nxt  = ST_IDLE;
         end
         ST_ERR: begin
            FETCH_ERR = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_fetch_sequencer.sv
// tb/tb_mem_fetch_sequencer.sv - directed self-checking bench for mem_fetch_sequencer
module tb_mem_fetch_sequencer;

   localparam int TO = 15;

   // Output bundle bit positions.
   localparam logic [8:0] O_MAR  = 9'h100;
   localparam logic [8:0] O_MOV  = 9'h080;
   localparam logic [8:0] O_RW   = 9'h040;
   localparam logic [8:0] O_MDR  = 9'h020;
   localparam logic [8:0] O_IR   = 9'h010;
   localparam logic [8:0] O_PCEN = 9'h008;
   localparam logic [8:0] O_BUSY = 9'h004;
   localparam logic [8:0] O_DONE = 9'h002;
   localparam logic [8:0] O_ERR  = 9'h001;

   logic        CLK = 1'b0;
   logic        RESET, FETCH_REQ, STALL, MFC;
   logic [31:0] PC_Q;
   logic        MAR_EN, MOV, RW, MDR_EN, IR_EN, PC_EN, BUSY, FETCH_DONE, FETCH_ERR;
   logic [31:0] PC_D;

   int n_checks = 0;
   int n_errors = 0;

   mem_fetch_sequencer #(.PC_INC(32'd4), .TIMEOUT_CYCLES(TO)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .FETCH_REQ  (FETCH_REQ),
      .STALL      (STALL),
      .PC_Q       (PC_Q),
      .MFC        (MFC),
      .MAR_EN     (MAR_EN),
      .MOV        (MOV),
      .RW         (RW),
      .MDR_EN     (MDR_EN),
      .IR_EN      (IR_EN),
      .PC_EN      (PC_EN),
      .PC_D       (PC_D),
      .BUSY       (BUSY),
      .FETCH_DONE (FETCH_DONE),
      .FETCH_ERR  (FETCH_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic expect_outs(input string tag, input logic [8:0] exp, input logic [31:0] exp_pcd);
      logic [8:0] obs;
      obs = {MAR_EN, MOV, RW, MDR_EN, IR_EN, PC_EN, BUSY, FETCH_DONE, FETCH_ERR};
      check_val({tag, ":outs"}, {23'd0, obs}, {23'd0, exp});
      check_val({tag, ":pcd"}, PC_D, exp_pcd);
   endtask

   task automatic cycle();
      @(posedge CLK);
      #1;
   endtask

   // One fetch from IDLE. mfc_at = MEM_WAIT cycle (1-based) where MFC is
   // raised; 0 means MFC never arrives (timeout path).
   task automatic run_fetch(input string tag, input logic [31:0] pc,
                            input int mfc_at, input logic [31:0] exp_pcd);
      PC_Q      = pc;
      FETCH_REQ = 1'b1;
      cycle();
      FETCH_REQ = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      if (pc[1:0] != 2'b00) begin
         expect_outs({tag, ":align_err"}, O_ERR | O_BUSY, 32'd0);
         cycle();
         expect_outs({tag, ":idle"}, 9'h000, 32'd0);
         return;
      end
`endif
      expect_outs({tag, ":mar"}, O_MAR | O_BUSY, 32'd0);
      for (int k = 1; k <= TO; k++) begin
         cycle();
         if (k == mfc_at) MFC = 1'b1;
         #1;
         if (k == mfc_at) begin
            expect_outs($sformatf("%s:mw%0d", tag, k), O_MOV | O_RW | O_MDR | O_BUSY, 32'd0);
            break;
         end
         expect_outs($sformatf("%s:mw%0d", tag, k), O_MOV | O_RW | O_BUSY, 32'd0);
      end
      cycle();
      MFC = 1'b0;
      if (mfc_at == 0) begin
         expect_outs({tag, ":err"}, O_ERR | O_BUSY, 32'd0);
      end else begin
         expect_outs({tag, ":ir"}, O_IR | O_PCEN | O_BUSY, exp_pcd);
         cycle();
         expect_outs({tag, ":done"}, O_DONE | O_BUSY, 32'd0);
      end
      cycle();
      expect_outs({tag, ":idle"}, 9'h000, 32'd0);
   endtask

   initial begin
      RESET     = 1'b1;
      FETCH_REQ = 1'b0;
      STALL     = 1'b0;
      MFC       = 1'b0;
      PC_Q      = 32'd0;
      cycle();
      cycle();
      expect_outs("reset", 9'h000, 32'd0);
      RESET = 1'b0;
      cycle();
      expect_outs("idle0", 9'h000, 32'd0);

      // MFC outside MEM_WAIT has no effect.
      MFC = 1'b1;
      cycle();
      expect_outs("mfc_idle", 9'h000, 32'd0);
      MFC = 1'b0;

      run_fetch("f100", 32'h0000_0100, 3, 32'h0000_0104);
      run_fetch("wrap", 32'hFFFF_FFFC, 1, 32'h0000_0000);
      run_fetch("tmo", 32'h0000_0200, 0, 32'd0);
      run_fetch("mfc15", 32'h0000_0300, TO, 32'h0000_0304);

      // Held-off request: nothing happens while STALL is high.
      PC_Q      = 32'h0000_0400;
      FETCH_REQ = 1'b1;
      STALL     = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         expect_outs($sformatf("stall%0d", i), 9'h000, 32'd0);
      end
      STALL = 1'b0;
      run_fetch("unstall", 32'h0000_0400, 1, 32'h0000_0404);

      // Reset while waiting on memory aborts the fetch.
      PC_Q      = 32'h0000_0500;
      FETCH_REQ = 1'b1;
      cycle();
      FETCH_REQ = 1'b0;
      expect_outs("rst_mar", O_MAR | O_BUSY, 32'd0);
      cycle();
      expect_outs("rst_mw", O_MOV | O_RW | O_BUSY, 32'd0);
      RESET = 1'b1;
      MFC   = 1'b1;
      cycle();
      MFC = 1'b0;
      expect_outs("rst_abort", 9'h000, 32'd0);
      RESET = 1'b0;
      cycle();
      expect_outs("rst_after", 9'h000, 32'd0);

      run_fetch("mis102", 32'h0000_0102, 1, 32'h0000_0106);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
